// File: rtl/stream_cipher_pkg.sv
// Types and constants shared by the stream_cipher block: generator status and key buffer states.
package stream_cipher_pkg;

  localparam int unsigned KEY_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEEDING,
    READY,
    BUSY
  } hash_generator_state_t;

  typedef enum logic [1:0] {
    K_EMPTY,
    K_PENDING,
    K_FULL
  } key_buf_state_t;

endpackage

// File: rtl/keystream_combiner.sv
// XORs each accepted data byte with one keystream byte fetched from the hash generator.
// A single-entry key buffer is refilled by a request/response exchange with a bounded wait.
module keystream_combiner
  import stream_cipher_pkg::*;
#(
  parameter bit          PREFETCH       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [KEY_BYTE_W-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [KEY_BYTE_W-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  request_hash_byte_pulse,
  input  logic [KEY_BYTE_W-1:0] hash_byte_in,
  input  logic                  hash_byte_pulse_in,
  input  hash_generator_state_t generator_state_in,
  output logic [31:0]           byte_count,
  output logic                  timeout_err,
  output logic                  spurious_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  key_buf_state_t        key_state_q, key_state_d;
  logic [KEY_BYTE_W-1:0] kbuf_q, kbuf_d;
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                  req_q, req_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  spurious_err_q, spurious_err_d;

  logic [KEY_BYTE_W-1:0] data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           byte_count_q, byte_count_d;

  logic                  in_ready;
  logic                  accept;
  logic                  xfer_out;

  assign in_ready = (key_state_q == K_FULL) && (!out_valid_q || data_out_ready);
  assign accept   = data_in_valid && in_ready;
  assign xfer_out = out_valid_q && data_out_ready;

  // Key buffer FSM: request, wait (bounded), hold until one data byte consumes it.
  always_comb begin
    key_state_d    = key_state_q;
    kbuf_d         = kbuf_q;
    wait_cnt_d     = wait_cnt_q;
    req_d          = 1'b0;
    timeout_err_d  = timeout_err_q;
    spurious_err_d = spurious_err_q;

    unique case (key_state_q)
      K_EMPTY: begin
        if ((generator_state_in == READY) && (PREFETCH || data_in_valid)) begin
          key_state_d = K_PENDING;
          req_d       = 1'b1;
          wait_cnt_d  = '0;
        end
      end
      K_PENDING: begin
        if (hash_byte_pulse_in) begin
          key_state_d = K_FULL;
          kbuf_d      = hash_byte_in;
          wait_cnt_d  = '0;
        end else if (wait_cnt_q == CntLast) begin
          key_state_d   = K_EMPTY;
          timeout_err_d = 1'b1;
          wait_cnt_d    = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      K_FULL: begin
        if (accept) begin
          key_state_d = K_EMPTY;
        end
      end
      default: key_state_d = K_EMPTY;
    endcase

    // A byte nobody asked for is dropped; only the sticky flag records it.
    if (hash_byte_pulse_in && (key_state_q != K_PENDING)) begin
      spurious_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_state_q    <= K_EMPTY;
      kbuf_q         <= '0;
      wait_cnt_q     <= '0;
      req_q          <= 1'b0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      key_state_q    <= key_state_d;
      kbuf_q         <= kbuf_d;
      wait_cnt_q     <= wait_cnt_d;
      req_q          <= req_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
    end
  end

  // Output register; an accept in the same cycle as a transfer refills it without a bubble.
  always_comb begin
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q;
    byte_count_d = byte_count_q;
    if (xfer_out) begin
      out_valid_d  = 1'b0;
      byte_count_d = byte_count_q + 32'd1;
    end
    if (accept) begin
      data_out_d  = data_in ^ kbuf_q;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign data_in_ready           = in_ready;
  assign data_out                = data_out_q;
  assign data_out_valid          = out_valid_q;
  assign request_hash_byte_pulse = req_q;
  assign byte_count              = byte_count_q;
  assign timeout_err             = timeout_err_q;
  assign spurious_err            = spurious_err_q;

endmodule

// File: tb/tb_keystream_combiner.sv
// Directed bench for keystream_combiner: table-driven data stream plus timeout/spurious/reset cases.
module tb_keystream_combiner;
  import stream_cipher_pkg::*;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic [7:0]            data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [7:0]            data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  request_hash_byte_pulse;
  logic [7:0]            hash_byte_in;
  logic                  hash_byte_pulse_in;
  hash_generator_state_t gen_state;
  logic [31:0]           byte_count;
  logic                  timeout_err;
  logic                  spurious_err;

  typedef struct {
    logic [7:0] din;
    logic [7:0] key;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] key_pool[8];
  logic [7:0] got_q[$];
  int         checks = 0;
  int         errors = 0;
  int         req_cnt = 0;
  bit         gen_auto = 1'b0;
  int         gen_idx = 0;
  int         man_req = 0;
  logic [7:0] man_byte = 8'h00;

  keystream_combiner #(
    .PREFETCH      (1'b1),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk                    (clk),
    .nrst                   (nrst),
    .data_in                (data_in),
    .data_in_valid          (data_in_valid),
    .data_in_ready          (data_in_ready),
    .data_out               (data_out),
    .data_out_valid         (data_out_valid),
    .data_out_ready         (data_out_ready),
    .request_hash_byte_pulse(request_hash_byte_pulse),
    .hash_byte_in           (hash_byte_in),
    .hash_byte_pulse_in     (hash_byte_pulse_in),
    .generator_state_in     (gen_state),
    .byte_count             (byte_count),
    .timeout_err            (timeout_err),
    .spurious_err           (spurious_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst && data_out_valid && data_out_ready) got_q.push_back(data_out);
    if (request_hash_byte_pulse) req_cnt++;
  end

  // Generator model: auto mode answers each request one cycle later; manual pulses on demand.
  initial begin
    int  man_done;
    bit  auto_due;
    man_done           = 0;
    auto_due           = 1'b0;
    hash_byte_in       = 8'h00;
    hash_byte_pulse_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      hash_byte_pulse_in = 1'b0;
      if (auto_due) begin
        hash_byte_in       = key_pool[gen_idx % 8];
        hash_byte_pulse_in = 1'b1;
        gen_idx++;
        auto_due = 1'b0;
      end else if (man_req != man_done) begin
        hash_byte_in       = man_byte;
        hash_byte_pulse_in = 1'b1;
        man_done           = man_req;
      end
      if (gen_auto && request_hash_byte_pulse) auto_due = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    @(negedge clk);
    while (!request_hash_byte_pulse && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 200), 32'd1);
  endtask

  // Offers one byte and returns just after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    data_in       = b;
    data_in_valid = 1'b1;
    #1;
    while (!data_in_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("send_accept", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  initial begin
    int rc;
    nrst           = 1'b0;
    data_in        = 8'h00;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    gen_state      = IDLE;

    vecs[0] = '{din: 8'h11, key: 8'h22, exp: 8'h33};
    vecs[1] = '{din: 8'hF0, key: 8'h0F, exp: 8'hFF};
    vecs[2] = '{din: 8'hAA, key: 8'hAA, exp: 8'h00};
    vecs[3] = '{din: 8'h5A, key: 8'hC3, exp: 8'h99};
    for (int i = 0; i < 4; i++) key_pool[i] = vecs[i].key;
    key_pool[4] = 8'h6E;
    key_pool[5] = 8'h81;
    key_pool[6] = 8'h5D;
    key_pool[7] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_out_valid", 32'(data_out_valid), 32'h0);
    check("rst_in_ready", 32'(data_in_ready), 32'h0);
    check("rst_request", 32'(request_hash_byte_pulse), 32'h0);
    check("rst_byte_count", byte_count, 32'h0);
    check("rst_errs", {30'h0, timeout_err, spurious_err}, 32'h0);
    check("rst_state", 32'(dut.key_state_q), 32'(K_EMPTY));

    // 1: one prefetch request, fill with A5, no second request
    @(posedge clk);
    #1;
    nrst      = 1'b1;
    gen_state = READY;
    wait_req("t1_req");
    man_byte = 8'hA5;
    man_req++;
    repeat (4) @(negedge clk);
    #1;
    check("t1_req_count", 32'(req_cnt), 32'd1);
    check("t1_state", 32'(dut.key_state_q), 32'(K_FULL));
    check("t1_kbuf", 32'(dut.kbuf_q), 32'hA5);
    check("t1_in_ready", 32'(data_in_ready), 32'd1);

    // 2: 3C ^ A5
    gen_auto       = 1'b1;
    data_out_ready = 1'b1;
    send_byte(8'h3C);
    @(negedge clk);
    check("t2_valid", 32'(data_out_valid), 32'd1);
    check("t2_data", 32'(data_out), 32'h99);
    check("t2_count_before", byte_count, 32'd0);
    @(negedge clk);
    check("t2_count", byte_count, 32'd1);
    check("t2_valid_drop", 32'(data_out_valid), 32'd0);

    // 3: table-driven back-to-back stream
    for (int i = 0; i < 4; i++) send_byte(vecs[i].din);
    repeat (3) @(negedge clk);
    check("t3_count", byte_count, 32'd5);
    check("t3_nout", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 4; i++) check($sformatf("t3_out%0d", i), 32'(got_q[i+1]), 32'(vecs[i].exp));

    // 4: downstream stall, then simultaneous transfer and accept
    data_out_ready = 1'b0;
    send_byte(8'h01);
    rc            = req_cnt;
    data_in       = 8'h02;
    data_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_data", 32'(data_out), 32'h6F);
      check("t4_hold_valid", 32'(data_out_valid), 32'd1);
      check("t4_in_ready", 32'(data_in_ready), 32'd0);
    end
    #1;
    check("t4_one_prefetch", 32'(req_cnt - rc), 32'd1);
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t4_refill_valid", 32'(data_out_valid), 32'd1);
    check("t4_refill_data", 32'(data_out), 32'h83);
    check("t4_count_mid", byte_count, 32'd6);
    @(negedge clk);
    check("t4_count", byte_count, 32'd7);
    check("t4_out5", 32'(got_q[5]), 32'h6F);
    check("t4_out6", 32'(got_q[6]), 32'h83);

    // 5: silent generator, exact timeout boundary, re-request
    send_byte(8'h00);
    gen_auto = 1'b0;
    wait_req("t5_req");
    repeat (63) @(negedge clk);
    check("t5_no_timeout_yet", 32'(timeout_err), 32'd0);
    check("t5_still_pending", 32'(dut.key_state_q), 32'(K_PENDING));
    @(negedge clk);
    check("t5_timeout", 32'(timeout_err), 32'd1);
    check("t5_empty", 32'(dut.key_state_q), 32'(K_EMPTY));
    check("t5_no_req_yet", 32'(request_hash_byte_pulse), 32'd0);
    @(negedge clk);
    check("t5_rereq", 32'(request_hash_byte_pulse), 32'd1);
    check("t5_out7", 32'(got_q[7]), 32'h5D);
    man_byte = 8'h77;
    man_req++;
    repeat (3) @(negedge clk);
    check("t5_full", 32'(dut.key_state_q), 32'(K_FULL));

    // 6: spurious pulse in K_FULL, then reset mid-pending and a late pulse
    man_byte = 8'hEE;
    man_req++;
    repeat (3) @(negedge clk);
    check("t6_spurious", 32'(spurious_err), 32'd1);
    check("t6_kbuf_kept", 32'(dut.kbuf_q), 32'h77);
    check("t6_state_kept", 32'(dut.key_state_q), 32'(K_FULL));
    check("t6_timeout_sticky", 32'(timeout_err), 32'd1);
    send_byte(8'h00);
    @(negedge clk);
    check("t6_data", 32'(data_out), 32'h77);
    wait_req("t6_req");
    #1;
    nrst = 1'b0;
    #1;
    check("t6_rst_data_out", 32'(data_out), 32'h0);
    check("t6_rst_valid", 32'(data_out_valid), 32'h0);
    check("t6_rst_count", byte_count, 32'h0);
    check("t6_rst_errs", {30'h0, timeout_err, spurious_err}, 32'h0);
    check("t6_rst_req", 32'(request_hash_byte_pulse), 32'h0);
    check("t6_rst_ready", 32'(data_in_ready), 32'h0);
    gen_state = BUSY;
    @(posedge clk);
    #1;
    nrst     = 1'b1;
    man_byte = 8'h12;
    man_req++;
    repeat (3) @(negedge clk);
    check("t6_late_spurious", 32'(spurious_err), 32'd1);
    check("t6_late_state", 32'(dut.key_state_q), 32'(K_EMPTY));
    #1;
    rc = req_cnt;
    repeat (5) @(negedge clk);
    #1;
    check("t6_busy_no_req", 32'(req_cnt - rc), 32'd0);
    gen_state = READY;
    wait_req("t6_ready_req");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
